// File: rtl/bcd_converter.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) feeding the 4-digit display.
// Define BCD_CONVERTER_SIGNED_EN to treat bin_in as two's complement and report the sign on negative.
module bcd_converter #(
  parameter int unsigned IN_WIDTH = 16,
  parameter bit          SATURATE = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [IN_WIDTH-1:0] bin_in,
  output logic                busy,
  output logic                done,
  output logic [15:0]         bcd_out,
  output logic                overflow,
  output logic                negative
);

  localparam int unsigned DIGITS = 5;
  localparam int unsigned ACC_W  = 4 * DIGITS;
  localparam int unsigned CNT_W  = $clog2(IN_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IN_WIDTH-1:0] shreg_q, shreg_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [15:0]         bcd_q, bcd_d;
  logic                ovf_q, ovf_d;
  logic                ovf_c;
  logic [IN_WIDTH-1:0] mag_c;
  logic [ACC_W-1:0]    acc_adj_c;

  // Add 3 to every BCD digit that is 5 or more, ahead of the shift.
  function automatic logic [ACC_W-1:0] add3(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] r;
    r = a;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = a[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  assign acc_adj_c = add3(acc_q);
  assign ovf_c     = (acc_q[ACC_W-1 -: 4] != 4'd0);

`ifdef BCD_CONVERTER_SIGNED_EN
  logic sign_c;
  logic sign_q, sign_d;
  logic neg_q, neg_d;

  // Unsigned IN_WIDTH-bit magnitude, so the most negative input maps to 2**(IN_WIDTH-1).
  assign sign_c   = bin_in[IN_WIDTH-1];
  assign mag_c    = sign_c ? ((~bin_in) + IN_WIDTH'(1)) : bin_in;
  assign negative = neg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      sign_q <= sign_d;
      neg_q  <= neg_d;
    end
  end

  always_comb begin
    sign_d = sign_q;
    neg_d  = neg_q;
    if (state_q == ST_IDLE && start) begin
      sign_d = sign_c;
    end
    if (state_q == ST_DONE) begin
      neg_d = sign_q;
    end
  end
`else
  assign mag_c    = bin_in;
  assign negative = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    shreg_d = shreg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    busy_d  = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shreg_d = mag_c;
          acc_d   = '0;
          cnt_d   = CNT_W'(IN_WIDTH);
        end
      end
      ST_SHIFT: begin
        acc_d   = {acc_adj_c[ACC_W-2:0], shreg_q[IN_WIDTH-1]};
        shreg_d = {shreg_q[IN_WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_DONE: begin
        ovf_d  = ovf_c;
        bcd_d  = (SATURATE && ovf_c) ? 16'h9999 : acc_q[15:0];
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= 16'h0000;
      ovf_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd_out  = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bcd_converter.sv
// Directed bench for bcd_converter: saturating and wrapping instances driven in parallel.
module tb_bcd_converter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] bin_in;

  logic        s_busy, s_done, s_ovf, s_neg;
  logic [15:0] s_bcd;
  logic        w_busy, w_done, w_ovf, w_neg;
  logic [15:0] w_bcd;

  int total = 0;
  int bad   = 0;

  bcd_converter #(.IN_WIDTH(16), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(s_busy), .done(s_done), .bcd_out(s_bcd), .overflow(s_ovf), .negative(s_neg)
  );

  bcd_converter #(.IN_WIDTH(16), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(w_busy), .done(w_done), .bcd_out(w_bcd), .overflow(w_ovf), .negative(w_neg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bin;
    logic [15:0] sat;
    logic [15:0] wrap;
    logic        ovf;
    logic        neg;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one conversion and report done latency (0 if never seen) and busy cycle count.
  task automatic run_conv(input logic [15:0] v, output int lat, output int busy_cnt);
    start    = 1'b1;
    bin_in   = v;
    tick();
    start    = 1'b0;
    lat      = 0;
    busy_cnt = s_busy ? 1 : 0;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (s_busy) busy_cnt++;
      if (s_done) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, bcnt, dones;

    vecs[0] = '{16'd1234,  16'h1234, 16'h1234, 1'b0, 1'b0};
    vecs[1] = '{16'd0,     16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[2] = '{16'd9999,  16'h9999, 16'h9999, 1'b0, 1'b0};
    vecs[3] = '{16'd10000, 16'h9999, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'd42,    16'h0042, 16'h0042, 1'b0, 1'b0};
`ifdef BCD_CONVERTER_SIGNED_EN
    vecs[4] = '{16'hFFFF,  16'h0001, 16'h0001, 1'b0, 1'b1};
    vecs[5] = '{16'hFF06,  16'h0250, 16'h0250, 1'b0, 1'b1};
    vecs[6] = '{16'h8000,  16'h9999, 16'h2768, 1'b1, 1'b1};
`else
    vecs[4] = '{16'hFFFF,  16'h9999, 16'h5535, 1'b1, 1'b0};
    vecs[5] = '{16'hFF06,  16'h9999, 16'h5286, 1'b1, 1'b0};
    vecs[6] = '{16'h8000,  16'h9999, 16'h2768, 1'b1, 1'b0};
`endif

    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = 16'd0;
    repeat (2) tick();
    check("rst_busy", {31'd0, s_busy}, 32'd0);
    check("rst_done", {31'd0, s_done}, 32'd0);
    check("rst_bcd",  {16'd0, s_bcd},  32'd0);
    check("rst_ovf",  {31'd0, s_ovf},  32'd0);
    check("rst_neg",  {31'd0, s_neg},  32'd0);
    #3 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_conv(vecs[i].bin, lat, bcnt);
      check($sformatf("v%0d_latency", i), lat, 32'd17);
      if (i == 0) check("v0_busy_cycles", bcnt, 32'd17);
      check($sformatf("v%0d_wdone", i),   {31'd0, w_done}, 32'd1);
      check($sformatf("v%0d_sat_bcd", i), {16'd0, s_bcd}, {16'd0, vecs[i].sat});
      check($sformatf("v%0d_wrap_bcd", i), {16'd0, w_bcd}, {16'd0, vecs[i].wrap});
      check($sformatf("v%0d_sat_ovf", i), {31'd0, s_ovf}, {31'd0, vecs[i].ovf});
      check($sformatf("v%0d_wrap_ovf", i), {31'd0, w_ovf}, {31'd0, vecs[i].ovf});
      check($sformatf("v%0d_neg", i),     {31'd0, s_neg}, {31'd0, vecs[i].neg});
      check($sformatf("v%0d_wneg", i),    {31'd0, w_neg}, {31'd0, vecs[i].neg});
      tick();
      check($sformatf("v%0d_done_pulse", i), {31'd0, s_done}, 32'd0);
      check($sformatf("v%0d_hold", i), {16'd0, s_bcd}, {16'd0, vecs[i].sat});
    end

    // Start pulse and bin_in change during a conversion must be ignored.
    start  = 1'b1;
    bin_in = 16'd555;
    tick();
    start  = 1'b0;
    dones  = 0;
    lat    = 0;
    for (int n = 1; n <= 25; n++) begin
      if (n == 5) begin
        start  = 1'b1;
        bin_in = 16'd999;
      end else if (n == 6) begin
        start  = 1'b0;
        bin_in = 16'd111;
      end
      tick();
      if (s_done) begin
        dones++;
        if (lat == 0) lat = n;
      end
    end
    check("ign_dones",   dones, 32'd1);
    check("ign_latency", lat,   32'd17);
    check("ign_bcd",     {16'd0, s_bcd}, 32'h0555);
    check("ign_wbcd",    {16'd0, w_bcd}, 32'h0555);
    check("ign_busy",    {31'd0, s_busy}, 32'd0);

    // Reset mid-conversion; preload an overflowing result so the clear is visible.
    run_conv(16'd10000, lat, bcnt);
    check("pre_rst_ovf", {31'd0, s_ovf}, 32'd1);
    tick();
    start  = 1'b1;
    bin_in = 16'd4321;
    tick();
    start  = 1'b0;
    repeat (7) tick();
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, s_busy}, 32'd0);
    check("mid_rst_done", {31'd0, s_done}, 32'd0);
    check("mid_rst_bcd",  {16'd0, s_bcd},  32'd0);
    check("mid_rst_ovf",  {31'd0, s_ovf},  32'd0);
    check("mid_rst_wbsy", {31'd0, w_busy}, 32'd0);
    tick();
    tick();
    #3 rst_n = 1'b1;
    dones = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (s_done || w_done) dones++;
    end
    check("post_rst_nodone", dones, 32'd0);
    run_conv(16'd4321, lat, bcnt);
    check("post_rst_lat", lat, 32'd17);
    check("post_rst_bcd", {16'd0, s_bcd}, 32'h4321);
    tick();

    // Start held high: accepted every 18 cycles.
    start  = 1'b1;
    bin_in = 16'd42;
    tick();
    lat = 0;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (s_done) begin
        lat = n;
        break;
      end
    end
    check("b2b_lat0", lat, 32'd17);
    check("b2b_bcd0", {16'd0, s_bcd}, 32'h0042);
    bin_in = 16'd77;
    tick();
    check("b2b_accept", {31'd0, s_busy}, 32'd1);
    lat = 0;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (s_done) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    check("b2b_lat1", lat, 32'd17);
    check("b2b_bcd1", {16'd0, s_bcd}, 32'h0077);
    check("b2b_wbcd1", {16'd0, w_bcd}, 32'h0077);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_converter.md
Name: bcd_converter

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Sits directly upstream of the 4-digit seven-segment display driver and supplies its 16-bit digit bus.
- Lets 4 decimal digits of a binary value (e.g. PC, register, counter) appear on the display instead of hex.
- Result is registered and held stable between conversions, so the display never shows partial results.

Parameters:
- IN_WIDTH, 16, width of binary input; legal range 4..16.
- SATURATE, 1, 1: value >9999 gives bcd_out=16'h9999; 0: gives value mod 10000 (low 4 BCD digits).

Ports:
- clk  input  1  system clock (100 MHz board clock)
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request conversion of bin_in; sampled only in IDLE
- bin_in  input  IN_WIDTH  binary value, captured on accepted start edge
- busy  output  1  high while a conversion is in progress (state != IDLE)
- done  output  1  one-cycle pulse; bcd_out/overflow/negative updated on the same edge
- bcd_out  output  16  four BCD digits, [15:12]=thousands ... [3:0]=ones; feeds display digits input
- overflow  output  1  magnitude >9999 on last conversion
- negative  output  1  last converted value was negative (intended for display dp_en)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, bcd_out=16'h0000, overflow=0, negative=0; scratch registers cleared.
- Reset mid-conversion aborts it; no done pulse; outputs return to reset values.
- Internal scratch: shift register IN_WIDTH bits, 5-digit (20-bit) BCD accumulator, bit counter of clog2(IN_WIDTH+1) bits.
- Three states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at an edge: capture bin_in (or magnitude, see Optional Feature), clear accumulator, counter=IN_WIDTH, go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT, each edge:
  - Every accumulator digit >=5 gets +3.
  - Then shift {accumulator, shift reg} left 1; input MSB enters accumulator bit 0.
  - Counter decrements; when it was 1, go to DONE.
  - Exactly IN_WIDTH SHIFT edges.
- DONE, one edge:
  - overflow = (digit4 != 0).
  - bcd_out = SATURATE&&overflow ? 16'h9999 : accumulator[15:0].
  - done=1 for that cycle only; go to IDLE.
- Latency: start accepted at edge 0 -> done/bcd_out visible after edge IN_WIDTH+1 (17 for default).
- Throughput: the next start is accepted at edge IN_WIDTH+2 (done cycle counts as IDLE for start); max one conversion per IN_WIDTH+2 cycles.
- start while busy=1 (SHIFT/DONE): ignored, not queued.
- Changes to bin_in after capture have no effect on the current conversion.
- bcd_out, overflow and negative hold their values until the next DONE edge or reset.
- busy = (state != IDLE); registered, no combinational path from start.
- Boundaries:
  - 0 -> 16'h0000.
  - 9999 -> 16'h9999, overflow=0.
  - 10000 -> overflow=1; bcd_out 16'h9999 (SATURATE=1) or 16'h0000 (SATURATE=0).
  - 65535 -> overflow=1; 16'h9999 or 16'h5535.

Optional Feature:
- Macro: BCD_CONVERTER_SIGNED_EN.
- Defined:
  - bin_in is two's complement.
  - On accepted start, capture |bin_in|, using an IN_WIDTH-bit unsigned magnitude so the most negative value is handled.
  - Latch the sign; negative is updated at DONE.
  - -32768 gives magnitude 32768 -> overflow=1.
- Not defined:
  - bin_in is unsigned.
  - negative is constant 0 (port still present).
  - No abs logic is synthesized.

Test Plan:
- Reset, then start with bin_in=16'd1234 -> busy high for 17 cycles; done pulses once at edge 17; bcd_out=16'h1234, overflow=0.
- Convert 0, then 9999 -> 16'h0000, then 16'h9999 with overflow=0; convert 10000 -> overflow=1, bcd_out=16'h9999 (SATURATE=1); repeat with SATURATE=0 on 65535 -> 16'h5535.
- Pulse start again at edge 5 of a conversion and change bin_in mid-conversion -> ignored; result matches originally captured value; only one done pulse.
- Deassert rst_n at edge 8 of a conversion of 4321 -> all outputs 0 immediately; no done pulse; a new start after release converts correctly.
- Back-to-back: start held high continuously with bin_in=42 then 77 -> conversions accepted every 18 cycles; bcd_out 16'h0042 then 16'h0077.
- With BCD_CONVERTER_SIGNED_EN: bin_in=-250 -> bcd_out=16'h0250, negative=1; -32768 -> overflow=1, negative=1; without macro, 16'hFF06 -> overflow=1, negative=0.
